// File: rtl/prim_ram_fifo_pkg.sv
// Shared constants and types for the RAM-backed FIFO controller and its
// output buffer.
package prim_ram_fifo_pkg;

  localparam int RamReadLatency = 1;
  localparam int OutDepth       = 2;

  typedef logic [1:0]                out_cnt_t;
  typedef logic [RamReadLatency-1:0] inflight_t;

endpackage

// File: rtl/prim_ram_2p_fifo_if.sv
// Write and read ready/valid streams of the RAM-backed FIFO. The slave
// modport is the FIFO side; master is the producer/consumer side.
interface prim_ram_2p_fifo_if #(
  parameter int Width = 32
) ();

  logic             wvalid;
  logic             wready;
  logic [Width-1:0] wdata;
  logic             rvalid;
  logic             rready;
  logic [Width-1:0] rdata;

  modport master (
    output wvalid, wdata, rready,
    input  wready, rvalid, rdata
  );

  modport slave (
    input  wvalid, wdata, rready,
    output wready, rvalid, rdata
  );

endinterface

// File: rtl/prim_ram_fifo_outbuf.sv
// Two-entry output buffer behind the RAM read port. Head is entry 0; a pop
// shifts before a same-cycle capture is appended.
module prim_ram_fifo_outbuf
  import prim_ram_fifo_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             capture_i,
  input  logic [Width-1:0] cap_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] head_o,
  output out_cnt_t         cnt_o
);

  logic [Width-1:0] data_q [OutDepth];
  logic [Width-1:0] data_d [OutDepth];
  out_cnt_t         cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (pop_i && (cnt_q != '0)) begin
      data_d[0] = data_q[1];
      cnt_d     = cnt_q - 1'b1;
    end
    if (capture_i) begin
      if (cnt_d == '0) begin
        data_d[0] = cap_data_i;
      end else begin
        data_d[1] = cap_data_i;
      end
      cnt_d = cnt_d + 1'b1;
    end
    // Flush wins over any same-cycle capture or pop.
    if (clr_i) begin
      data_d = '{default: '0};
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '{default: '0};
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = data_q[0];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/prim_ram_2p_fifo.sv
// FIFO controller for an external two-port RAM: port A writes, port B reads,
// and a 2-entry buffer turns the registered RAM read into a ready/valid stream.
module prim_ram_2p_fifo
  import prim_ram_fifo_pkg::*;
#(
  parameter int Width  = 32,
  parameter int Depth  = 128,
  parameter int Aw     = $clog2(Depth),
  parameter int DepthW = $clog2(Depth + 3)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  prim_ram_2p_fifo_if.slave  bus,
  output logic [DepthW-1:0]  depth_o,
  output logic               full_o,
  output logic               ram_a_req_o,
  output logic               ram_a_write_o,
  output logic [Aw-1:0]      ram_a_addr_o,
  output logic [Width-1:0]   ram_a_wdata_o,
  output logic               ram_b_req_o,
  output logic               ram_b_write_o,
  output logic [Aw-1:0]      ram_b_addr_o,
  input  logic [Width-1:0]   ram_b_rdata_i
);

  localparam int              CntW    = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);
  localparam logic [Aw-1:0]   PtrLast = Aw'(Depth - 1);

  function automatic logic [Aw-1:0] ptr_inc(logic [Aw-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  logic [Aw-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  ram_cnt_q, ram_cnt_d;
  inflight_t        inflight_q, inflight_d;

  logic             flush, ram_full, ram_empty;
  logic             wr_fire, rd_issue, pop;
  logic [2:0]       occ;
  out_cnt_t         out_cnt;
  logic             out_valid;
  logic [Width-1:0] out_head;

  assign flush     = rst_i | clr_i;
  assign ram_full  = (ram_cnt_q == CntFull);
  assign ram_empty = (ram_cnt_q == '0);
  assign wr_fire   = bus.wvalid & ~ram_full & ~flush;
  assign pop       = out_valid & bus.rready & ~flush;

  // Issue only if the word will have a buffer slot when it returns next cycle.
  assign occ      = {1'b0, out_cnt} + 3'(inflight_q);
  assign rd_issue = ~flush & ~ram_empty & (occ < (3'(OutDepth) + {2'b00, pop}));

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ram_cnt_d  = ram_cnt_q;
    inflight_d = inflight_t'(rd_issue);
    if (wr_fire)  wptr_d = ptr_inc(wptr_q);
    if (rd_issue) rptr_d = ptr_inc(rptr_q);
    case ({wr_fire, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
      2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
      default: ram_cnt_d = ram_cnt_q;
    endcase
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  prim_ram_fifo_outbuf #(
    .Width (Width)
  ) u_outbuf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (flush),
    .capture_i  (inflight_q[0]),
    .cap_data_i (ram_b_rdata_i),
    .pop_i      (pop),
    .valid_o    (out_valid),
    .head_o     (out_head),
    .cnt_o      (out_cnt)
  );

  assign full_o     = ram_full & ~flush;
  assign bus.wready = ~full_o;
  assign bus.rvalid = out_valid & ~flush;
  assign bus.rdata  = flush ? '0 : out_head;

  assign depth_o = flush ? '0
                 : DepthW'(ram_cnt_q) + DepthW'(inflight_q) + DepthW'(out_cnt);

  assign ram_a_req_o   = wr_fire;
  assign ram_a_write_o = wr_fire;
  assign ram_a_addr_o  = wptr_q;
  assign ram_a_wdata_o = bus.wdata;

  assign ram_b_req_o   = rd_issue;
  assign ram_b_write_o = 1'b0;
  assign ram_b_addr_o  = rptr_q;

endmodule

// File: tb/tb_prim_ram_2p_fifo.sv
// Bench for prim_ram_2p_fifo with Depth = 5 and a behavioural two-port RAM.
// A monitor scoreboards accepted writes against popped reads.
module tb_prim_ram_2p_fifo;

  localparam int Width  = 32;
  localparam int Depth  = 5;
  localparam int Aw     = $clog2(Depth);
  localparam int DepthW = $clog2(Depth + 3);

  logic              clk = 1'b0;
  logic              rst, clr;
  logic [DepthW-1:0] depth;
  logic              full;
  logic              a_req, a_write, b_req, b_write;
  logic [Aw-1:0]     a_addr, b_addr;
  logic [Width-1:0]  a_wdata, b_rdata;
  logic [Width-1:0]  mem [8];

  always #5 clk = ~clk;

  prim_ram_2p_fifo_if #(.Width(Width)) bus ();

  prim_ram_2p_fifo #(
    .Width (Width),
    .Depth (Depth)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clr_i         (clr),
    .bus           (bus),
    .depth_o       (depth),
    .full_o        (full),
    .ram_a_req_o   (a_req),
    .ram_a_write_o (a_write),
    .ram_a_addr_o  (a_addr),
    .ram_a_wdata_o (a_wdata),
    .ram_b_req_o   (b_req),
    .ram_b_write_o (b_write),
    .ram_b_addr_o  (b_addr),
    .ram_b_rdata_i (b_rdata)
  );

  always @(posedge clk) begin
    if (a_req && a_write) mem[a_addr] <= a_wdata;
    if (b_req) b_rdata <= mem[b_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [31:0] exp_q [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic        stall_q;
    logic [31:0] stall_data;
    stall_q    = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        exp_q.delete();
      end else begin
        if (stall_q) begin
          check("stall_valid", 32'(bus.rvalid), 32'd1);
          check("stall_data", bus.rdata, stall_data);
        end
        if (bus.rvalid && bus.rready) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pop_unexpected: got %h expected no word", bus.rdata);
          end else begin
            check("rdata_order", bus.rdata, exp_q.pop_front());
          end
        end
        if (bus.wvalid && bus.wready) exp_q.push_back(bus.wdata);
      end
      stall_q    = !rst && !clr && bus.rvalid && !bus.rready;
      stall_data = bus.rdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepted, base, first, last, sent, n_rv;

    // Reset held 3 cycles with a write pending
    rst = 1'b1; clr = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h1111_1111; bus.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_a_req", 32'(a_req), 32'd0);
      check("rst_b_req", 32'(b_req), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd1);
      check("rst_depth", 32'(depth), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    tick();
    rst = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("post_rst_wready", 32'(bus.wready), 32'd1);
    check("post_rst_depth", 32'(depth), 32'd0);
    check("post_rst_full", 32'(full), 32'd0);
    check("post_rst_rdata", bus.rdata, 32'd0);

    // Single word latency
    tick();
    bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.rready = 1'b1;
    @(negedge clk);
    check("sw_wready", 32'(bus.wready), 32'd1);
    check("sw_a_req", 32'(a_req), 32'd1);
    check("sw_a_addr", 32'(a_addr), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) bus.wvalid = 1'b0;
      @(negedge clk);
      check("sw_depth", 32'(depth), (k <= 3) ? 32'd1 : 32'd0);
      check("sw_rvalid", 32'(bus.rvalid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check("sw_rdata", bus.rdata, 32'hDEAD_BEEF);
    end

    // Fill to Depth+2 with no reads, then drain
    tick();
    clr = 1'b1; bus.rready = 1'b0;
    tick();
    clr = 1'b0;
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 7; c++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = 32'hA000_0000 + 32'(accepted);
      @(negedge clk);
      if (bus.wready) begin
        check("fill_addr", 32'(a_addr), 32'(accepted % 5));
        accepted++;
      end
      tick();
    end
    check("fill_count", 32'(accepted), 32'd7);
    bus.wdata = 32'hA000_0007;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_flag", 32'(full), 32'd1);
      check("full_wready", 32'(bus.wready), 32'd0);
      check("full_depth", 32'(depth), 32'd7);
      check("full_a_req", 32'(a_req), 32'd0);
      tick();
    end
    bus.wvalid = 1'b0; bus.rready = 1'b1;
    base = n_pops;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (depth == '0) break;
      tick();
    end
    check("drain_depth", 32'(depth), 32'd0);
    check("drain_pops", 32'(n_pops - base), 32'd7);

    // Streaming 200 words
    base = n_pops; first = -1; last = -1; sent = 0; n_rv = 0;
    for (int c = 0; c < 230; c++) begin
      tick();
      bus.wvalid = (sent < 200);
      bus.wdata  = 32'h5000_0000 + 32'(sent);
      @(negedge clk);
      if (bus.wvalid && bus.wready) sent++;
      if (bus.rvalid) begin
        if (first < 0) first = c;
        last = c;
        n_rv++;
      end
    end
    bus.wvalid = 1'b0;
    check("stream_sent", 32'(sent), 32'd200);
    check("stream_first", 32'(first), 32'd3);
    check("stream_last", 32'(last), 32'd202);
    check("stream_rv_cycles", 32'(n_rv), 32'd200);
    check("stream_pops", 32'(n_pops - base), 32'd200);

    // Random valid/ready
    for (int c = 0; c < 1000; c++) begin
      tick();
      bus.wvalid = 1'($urandom_range(0, 1));
      bus.wdata  = $urandom;
      bus.rready = 1'($urandom_range(0, 1));
    end
    tick();
    bus.wvalid = 1'b0; bus.rready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (depth == '0) break;
      tick();
    end
    check("rand_drain_depth", 32'(depth), 32'd0);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear right after a read issue with 4 words held
    tick();
    bus.rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = 32'h3000_0000 + 32'(i);
      @(negedge clk);
      tick();
    end
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check("clr_held", 32'(depth), 32'd4);
    tick();
    bus.rready = 1'b1;
    @(negedge clk);
    check("clr_issue", 32'(b_req), 32'd1);
    tick();
    bus.rready = 1'b0; clr = 1'b1;
    bus.wvalid = 1'b1; bus.wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("clr_depth", 32'(depth), 32'd0);
    check("clr_rvalid", 32'(bus.rvalid), 32'd0);
    check("clr_a_req", 32'(a_req), 32'd0);
    check("clr_b_req", 32'(b_req), 32'd0);
    check("clr_rdata", bus.rdata, 32'd0);
    tick();
    clr = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("post_clr_depth", 32'(depth), 32'd0);
    check("post_clr_rvalid", 32'(bus.rvalid), 32'd0);
    check("post_clr_rdata", bus.rdata, 32'd0);
    check("post_clr_full", 32'(full), 32'd0);
    tick();
    bus.wvalid = 1'b1; bus.wdata = 32'hC0FF_EE00; bus.rready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) bus.wvalid = 1'b0;
      @(negedge clk);
      check("clr_new_rvalid", 32'(bus.rvalid), (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) check("clr_new_rdata", bus.rdata, 32'hC0FF_EE00);
    end
    tick();
    bus.rready = 1'b0;
    @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_depth", 32'(depth), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
